// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, main-decoder classes and R-type funct values.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps main-decoder class and funct to the 4-bit ALU code.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_cont,
  output logic       illegal
);

  always_comb begin
    alu_cont = ALU_ADD;
    illegal  = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: alu_cont = ALU_ADD;
      ALUOP_SUB: alu_cont = ALU_SUB;
      ALUOP_OR:  alu_cont = ALU_OR;
      ALUOP_RTYPE: begin
        unique case (funct)
          FUNCT_ADD: alu_cont = ALU_ADD;
          FUNCT_SUB: alu_cont = ALU_SUB;
          FUNCT_AND: alu_cont = ALU_AND;
          FUNCT_OR:  alu_cont = ALU_OR;
          FUNCT_XOR: alu_cont = ALU_XOR;
          default: begin
            alu_cont = ALU_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
      default: alu_cont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// EX issue stage: decodes, drives the external ALU and registers one EX/MEM slot.
// Optional EX_FWD_EN bypasses the slot result back onto operand A/B.
module ex_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic [DATA_W-1:0]  imm,
  input  logic               alu_src,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_write,
  input  logic               flush,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [3:0]         alu_cont,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic [DATA_W-1:0]  out_store,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic               out_illegal
);

  logic              illegal;
  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_cont (alu_cont),
    .illegal  (illegal)
  );

`ifdef EX_FWD_EN
  logic slot_wr;
  logic fwd_a;
  logic fwd_b;

  // Only a live, writing, non-r0 slot may bypass.
  assign slot_wr = out_valid & out_reg_write & (out_rd != '0);
  assign fwd_a   = slot_wr & (out_rd == rs_addr);
  assign fwd_b   = slot_wr & (out_rd == rt_addr);
  assign op_a    = fwd_a ? out_result : rs_data;
  assign op_b    = fwd_b ? out_result : rt_data;
`else
  logic addr_unused;

  assign addr_unused = ^{rs_addr, rt_addr};
  assign op_a        = rs_data;
  assign op_b        = rt_data;
`endif

  assign alu_in1  = op_a;
  assign alu_in2  = alu_src ? imm : op_b;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_store     <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_result    <= alu_out;
      out_zero      <= alu_z;
      out_store     <= op_b;
      out_rd        <= rd_addr;
      out_reg_write <= reg_write;
      out_illegal   <= illegal;
    end else if (out_ready | flush) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage with a behavioural ALU and scoreboard.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] imm = '0;
  logic        alu_src = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        reg_write = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_cont;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero;
  logic [31:0] out_store;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic        m_valid = 1'b0;
  logic [4:0]  m_rd = '0;
  logic        m_rw = 1'b0;
  logic [31:0] m_res = '0;

  always #5 clk = ~clk;

  ex_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alu_src(alu_src),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .reg_write(reg_write), .flush(flush),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cont(alu_cont),
    .alu_out(alu_out), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_store(out_store), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd6:    return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // behavioural 32-bit ALU standing in for the real one
  always_comb begin
    alu_out = ref_alu(alu_in1, alu_in2, alu_cont);
    alu_z   = (alu_out == 32'd0);
  end

  function automatic logic [3:0] ref_cont(logic [1:0] op, logic [5:0] f);
    if (op == 2'b00) return 4'd2;
    if (op == 2'b01) return 4'd6;
    if (op == 2'b11) return 4'd1;
    case (f)
      6'b100000: return 4'd2;
      6'b100010: return 4'd6;
      6'b100100: return 4'd0;
      6'b100101: return 4'd1;
      6'b100110: return 4'd3;
      default:   return 4'd2;
    endcase
  endfunction

  function automatic logic ref_ill(logic [1:0] op, logic [5:0] f);
    if (op != 2'b10) return 1'b0;
    return !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110});
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard + slot model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      logic [31:0] a, b, r;
      logic        acc;
      exp_t        e;
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, !m_valid || out_ready);
      if (in_valid) check("alu_cont", alu_cont, ref_cont(alu_op, funct));
      a = rs_data;
      b = rt_data;
`ifdef EX_FWD_EN
      if (m_valid && m_rw && m_rd != 0 && m_rd == rs_addr) a = m_res;
      if (m_valid && m_rw && m_rd != 0 && m_rd == rt_addr) b = m_res;
`endif
      acc = in_valid && (!m_valid || out_ready) && !flush;
      if (out_valid && out_ready) begin
        check("sb_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("result", out_result, e.result);
          check("zero", out_zero, e.zero);
          check("store", out_store, e.store);
          check("rd", out_rd, e.rd);
          check("reg_write", out_reg_write, e.rw);
          check("illegal", out_illegal, e.ill);
        end
      end else if (m_valid && flush && q.size() != 0) begin
        void'(q.pop_front());
      end
      if (acc) begin
        r = ref_alu(a, alu_src ? imm : b, ref_cont(alu_op, funct));
        e.result = r;
        e.zero   = (r == 32'd0);
        e.store  = b;
        e.rd     = rd_addr;
        e.rw     = reg_write;
        e.ill    = ref_ill(alu_op, funct);
        q.push_back(e);
        m_valid = 1'b1;
        m_rd    = rd_addr;
        m_rw    = reg_write;
        m_res   = r;
      end else if (out_ready || flush) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [5:0] f, logic [31:0] rs,
                       logic [31:0] rt, logic [31:0] im, logic src,
                       logic [4:0] rsa, logic [4:0] rta, logic [4:0] rd, logic rw);
    in_valid  = v;
    alu_op    = op;
    funct     = f;
    rs_data   = rs;
    rt_data   = rt;
    imm       = im;
    alu_src   = src;
    rs_addr   = rsa;
    rt_addr   = rta;
    rd_addr   = rd;
    reg_write = rw;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] fwd_exp;

    step();
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_result", out_result, 32'd0);
    check("rst_rd", out_rd, 5'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    step();

    // sub 10-3
    drive(1, 2'b10, 6'b100010, 32'd10, 32'd3, 0, 0, 1, 2, 5'd3, 1);
    #1 check("t1_cont", alu_cont, 4'd6);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_result", out_result, 32'd7);
    check("t1_zero", out_zero, 1'b0);
    check("t1_valid", out_valid, 1'b1);

    // addi 5 + -5
    drive(1, 2'b00, 6'd0, 32'd5, 32'd9, 32'hFFFF_FFFB, 1, 1, 2, 5'd6, 1);
    #1 check("t2_cont", alu_cont, 4'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_result", out_result, 32'd0);
    check("t2_zero", out_zero, 1'b1);
    step();

    // back-to-back with stall on the second beat
    drive(1, 2'b10, 6'b100101, 32'hF0, 32'h0F, 0, 0, 1, 2, 5'd7, 1);
    step();
    drive(1, 2'b10, 6'b100110, 32'hFF, 32'h0F, 0, 0, 1, 2, 5'd8, 1);
    out_ready = 1'b0;
    #1 check("t3_in_ready_stall", in_ready, 1'b0);
    held = out_result;
    check("t3_first", held, 32'hFF);
    step();
    check("t3_hold", out_result, held);
    check("t3_hold_rd", out_rd, 5'd7);
    out_ready = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_second", out_result, 32'hF0);
    check("t3_second_rd", out_rd, 5'd8);
    step();

    // illegal funct, then flush
    drive(1, 2'b10, 6'b101010, 32'd1, 32'd2, 0, 0, 1, 2, 5'd9, 1);
    #1 check("t4_cont", alu_cont, 4'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_illegal", out_illegal, 1'b1);
    step();
    drive(1, 2'b00, 6'd0, 32'd4, 32'd4, 0, 0, 1, 2, 5'd10, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_flush_drop", out_valid, 1'b0);
    // flush squashes a stalled slot
    out_ready = 1'b0;
    drive(1, 2'b01, 6'd0, 32'd9, 32'd4, 0, 0, 1, 2, 5'd11, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_flush_slot", out_valid, 1'b0);
    out_ready = 1'b1;
    step();

    // bypass: r4=0x10, then rs=r4 with stale data
    drive(1, 2'b00, 6'd0, 32'h10, 0, 0, 1, 0, 0, 5'd4, 1);
    step();
    drive(1, 2'b00, 6'd0, 32'h0, 0, 32'd1, 1, 5'd4, 0, 5'd5, 1);
`ifdef EX_FWD_EN
    fwd_exp = 32'h11;
`else
    fwd_exp = 32'h1;
`endif
    step();
    check("t5_fwd", out_result, fwd_exp);
    // r0 never bypasses
    drive(1, 2'b00, 6'd0, 32'h22, 0, 0, 1, 0, 0, 5'd0, 1);
    step();
    drive(1, 2'b00, 6'd0, 32'h0, 0, 32'd1, 1, 5'd0, 0, 5'd5, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_r0", out_result, 32'h1);
    step();

    // random stream with random backpressure
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [5:0] f;
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 5) == 0) ? 6'b111111 : 6'(6'b100000 + $urandom_range(0, 6));
      drive($urandom_range(0, 3) != 0, op, f, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    step();
    check("sb_drained", q.size(), 0);

    // async reset during a stall
    out_ready = 1'b0;
    drive(1, 2'b00, 6'd0, 32'd3, 32'd3, 0, 0, 1, 2, 5'd12, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_stalled", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1 check("t6_async_valid", out_valid, 1'b0);
    check("t6_async_ready", in_ready, 1'b1);
    check("t6_async_result", out_result, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
